// File: rtl/booth_ctrl.sv
// Sequencing FSM for the radix-4 Booth multiplier datapath (8x8 signed -> 16-bit).
// Loads operands, then runs ITERATIONS add/shift pairs. Each Booth digit is decoded
// from the datapath status into an ALU function. A start/busy/done handshake faces
// the requester. A sticky err flags a datapath count that disagrees with our own.
module booth_ctrl #(
    parameter int ITERATIONS = 4,
    parameter bit SKIP_ZERO  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [5:0] status,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       dp_load,
    output logic       xld,
    output logic       cntld,
    output logic       pld,
    output logic       ald,
    output logic       control,
    output logic [2:0] funsel
);

    // Iteration counter width; at least one bit so ITERATIONS=1 still elaborates.
    localparam int CW   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    // Compare width wide enough for both the 3-bit datapath count and our counter.
    localparam int CMPW = (CW > 3) ? CW : 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   iter_reg, iter_next;
    logic            err_reg, err_next;

    logic [2:0]      booth_fs;
    logic            digit_zero;
    logic [CMPW-1:0] cnt_ext;
    logic [CMPW-1:0] iter_ext;
    logic            cnt_match;
    logic            last_iter;

    // Booth digit decode of the triplet {b(i+1), b(i), b(i-1)} into {sel1x, sel2x, negate}.
    always_comb begin
        booth_fs   = 3'b000;
        digit_zero = 1'b0;
        case (status[2:0])
            3'b000, 3'b111: begin
                booth_fs   = 3'b000;
                digit_zero = 1'b1;
            end
            3'b001, 3'b010: booth_fs = 3'b100;
            3'b011:         booth_fs = 3'b010;
            3'b100:         booth_fs = 3'b011;
            3'b101, 3'b110: booth_fs = 3'b101;
            default:        booth_fs = 3'b000;
        endcase
    end

    assign cnt_ext   = CMPW'(status[5:3]);
    assign iter_ext  = CMPW'(iter_reg);
    assign cnt_match = (cnt_ext == iter_ext);
    assign last_iter = (iter_ext == CMPW'(ITERATIONS - 1));

    // State, iteration counter and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            iter_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic and per-state output decode; everything defaults to idle values.
    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        err_next   = err_reg;
        busy       = 1'b0;
        done       = 1'b0;
        dp_load    = 1'b0;
        xld        = 1'b0;
        cntld      = 1'b0;
        pld        = 1'b0;
        control    = 1'b0;
        funsel     = 3'b000;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    err_next   = 1'b0;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                dp_load    = 1'b1;
                iter_next  = '0;
                state_next = S_ADD;
            end
            S_ADD: begin
                busy       = 1'b1;
                control    = 1'b0;
                funsel     = booth_fs;
                // A zero digit adds nothing, so p can be left untouched.
                pld        = !(SKIP_ZERO && digit_zero);
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy    = 1'b1;
                control = 1'b1;
                pld     = 1'b1;
                xld     = 1'b1;
                cntld   = 1'b1;
                if (!cnt_match) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else if (last_iter) begin
                    state_next = S_DONE;
                end else begin
                    iter_next  = iter_reg + CW'(1);
                    state_next = S_ADD;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign err = err_reg;
    // The a register is loaded through dp_load only.
    assign ald = 1'b0;

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl. Two instances (SKIP_ZERO=1 and SKIP_ZERO=0) share
// the stimulus and a status stub. A timeline model checks every output on every cycle:
// position within an operation, with the Booth digit computed arithmetically.
module tb_booth_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] x;
    logic [2:0] stub_cnt;
    logic       freeze;
    logic [5:0] status;

    logic busy1, done1, err1, dp_load1, xld1, cntld1, pld1, ald1, control1;
    logic [2:0] funsel1;
    logic busy2, done2, err2, dp_load2, xld2, cntld2, pld2, ald2, control2;
    logic [2:0] funsel2;

    always #5 clk = ~clk;

    assign status = {stub_cnt, x};

    booth_ctrl #(.ITERATIONS(4), .SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .status(status),
        .busy(busy1), .done(done1), .err(err1), .dp_load(dp_load1), .xld(xld1),
        .cntld(cntld1), .pld(pld1), .ald(ald1), .control(control1), .funsel(funsel1)
    );

    booth_ctrl #(.ITERATIONS(4), .SKIP_ZERO(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .status(status),
        .busy(busy2), .done(done2), .err(err2), .dp_load(dp_load2), .xld(xld2),
        .cntld(cntld2), .pld(pld2), .ald(ald2), .control(control2), .funsel(funsel2)
    );

    // Datapath count stub: cleared by dp_load, counts cntld unless frozen.
    always_ff @(posedge clk) begin
        if (!reset_n)                stub_cnt <= 3'd0;
        else if (dp_load1)           stub_cnt <= 3'd0;
        else if (cntld1 && !freeze)  stub_cnt <= stub_cnt + 3'd1;
    end

    typedef struct {
        logic [2:0] x;
        logic [2:0] fs;
        logic       pld_skip;
    } vec_t;
    vec_t tab [8];

    int   n_vec = 0;
    int   n_mis = 0;
    int   m_pos = 0;      // 0 idle, 1 load, 2..9 add/shift, 10 done
    logic m_err = 1'b0;
    int   tab_idx = -1;
    bit   rand_x = 1'b0;
    int   op_cyc, n_busy, n_cntld, n_done, n_load, done_at, load2_at;
    int   op_num = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] ref_fs(input logic [2:0] xx);
        int b2, b1, b0, d;
        b2 = int'(xx[2]);
        b1 = int'(xx[1]);
        b0 = int'(xx[0]);
        d  = b1 + b0 - 2 * b2;
        if (d == 0) return 3'b000;
        return {(d == 1 || d == -1), (d == 2 || d == -2), (d < 0)};
    endfunction

    task automatic clear_counts();
        op_cyc = 0; n_busy = 0; n_cntld = 0; n_done = 0; n_load = 0;
        done_at = -1; load2_at = -1;
    endtask

    // Compare every output of both instances against the timeline model.
    task automatic check_cycle();
        logic add, shift, e_busy, e_load, e_done, nz;
        logic [2:0]  fs;
        logic [11:0] e1, e2, g1, g2;
        e_busy = (m_pos != 0);
        e_load = (m_pos == 1);
        e_done = (m_pos == 10);
        add    = (m_pos >= 2 && m_pos <= 8 && (m_pos % 2) == 0);
        shift  = (m_pos >= 3 && m_pos <= 9 && (m_pos % 2) == 1);
        nz     = (ref_fs(x) != 3'b000);
        fs     = add ? ref_fs(x) : 3'b000;
        e1 = {e_busy, e_done, m_err, e_load, shift, shift, (add && nz) || shift, 1'b0, shift, fs};
        e2 = {e_busy, e_done, m_err, e_load, shift, shift, add || shift,         1'b0, shift, fs};
        g1 = {busy1, done1, err1, dp_load1, xld1, cntld1, pld1, ald1, control1, funsel1};
        g2 = {busy2, done2, err2, dp_load2, xld2, cntld2, pld2, ald2, control2, funsel2};
        check("outs_skip1", {4'b0, g1}, {4'b0, e1});
        check("outs_skip0", {4'b0, g2}, {4'b0, e2});
        if (add && tab_idx >= 0) begin
            check("tab_funsel", {13'b0, funsel1}, {13'b0, tab[tab_idx].fs});
            check("tab_pld_skip1", {15'b0, pld1}, {15'b0, tab[tab_idx].pld_skip});
            check("tab_pld_skip0", {15'b0, pld2}, 16'd1);
        end
        op_cyc++;
        if (busy1) n_busy++;
        if (cntld1) n_cntld++;
        if (done1) begin n_done++; done_at = op_cyc; end
        if (dp_load1) begin n_load++; if (n_load == 2) load2_at = op_cyc; end
    endtask

    // One clock: advance the model from pre-edge inputs, then check #1 after the edge.
    task automatic step();
        int   np, it;
        logic ne;
        np = m_pos;
        ne = m_err;
        if (m_pos == 0) begin
            if (start) begin np = 1; ne = 1'b0; end
        end else if (m_pos == 1) begin
            np = 2;
        end else if (m_pos <= 9 && (m_pos % 2) == 0) begin
            np = m_pos + 1;
        end else if (m_pos <= 9) begin
            it = (m_pos - 3) / 2;
            if (int'(stub_cnt) != it) begin ne = 1'b1; np = 0; end
            else np = m_pos + 1;
        end else begin
            np = 0;
        end
        if (!reset_n) begin np = 0; ne = 1'b0; end
        @(posedge clk);
        m_pos = np;
        m_err = ne;
        #1;
        check_cycle();
        if (rand_x) x = 3'($urandom_range(0, 7));
    endtask

    task automatic run_op(input bit exp_err);
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && m_pos != 0; i++) step();
        op_num++;
        if (!exp_err) begin
            check("busy_cycles", 16'(n_busy), 16'd10);
            check("cntld_pulses", 16'(n_cntld), 16'd4);
            check("done_count", 16'(n_done), 16'd1);
            check("done_cycle", 16'(done_at), 16'd10);
        end else begin
            check("err_done_count", 16'(n_done), 16'd0);
            check("err_flag", {15'b0, err1}, 16'd1);
            check("err_cntld", 16'(n_cntld), 16'd2);
        end
        $display("op %0d: busy=%0d cntld=%0d done_at=%0d err=%0b", op_num, n_busy, n_cntld, done_at, err1);
    endtask

    initial begin
        tab[0] = '{3'b000, 3'b000, 1'b0};
        tab[1] = '{3'b001, 3'b100, 1'b1};
        tab[2] = '{3'b010, 3'b100, 1'b1};
        tab[3] = '{3'b011, 3'b010, 1'b1};
        tab[4] = '{3'b100, 3'b011, 1'b1};
        tab[5] = '{3'b101, 3'b101, 1'b1};
        tab[6] = '{3'b110, 3'b101, 1'b1};
        tab[7] = '{3'b111, 3'b000, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        x       = 3'b000;
        freeze  = 1'b0;

        // Reset held for two cycles: everything idle and zero.
        clear_counts();
        step();
        step();
        reset_n = 1'b1;

        // Basic operation with per-cycle random digits.
        rand_x = 1'b1;
        run_op(1'b0);

        // Table of every Booth triplet, digit held for a whole operation.
        rand_x = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = tab[i].x;
            tab_idx = i;
            run_op(1'b0);
        end
        tab_idx = -1;

        // start held for 20 cycles: exactly two operations, no restart while busy.
        rand_x = 1'b1;
        clear_counts();
        start = 1'b1;
        repeat (20) step();
        start = 1'b0;
        repeat (12) step();
        check("held_start_loads", 16'(n_load), 16'd2);
        check("held_start_load2", 16'(load2_at), 16'd12);
        check("held_start_dones", 16'(n_done), 16'd2);
        $display("held start: loads=%0d second_load_at=%0d dones=%0d", n_load, load2_at, n_done);

        // Frozen datapath count: error after second SHIFT, next start clears it.
        freeze = 1'b1;
        run_op(1'b1);
        freeze = 1'b0;
        step();
        check("err_sticky", {15'b0, err1}, 16'd1);
        run_op(1'b0);
        check("err_cleared", {15'b0, err1}, 16'd0);

        // Reset asserted during the third ADD aborts without done.
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12 && m_pos != 6; i++) step();
        check("reached_add3", 16'(m_pos), 16'd6);
        #2;
        reset_n = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
        #1;
        check_cycle();
        step();
        step();
        check("abort_done", 16'(n_done), 16'd0);
        $display("abort: done=%0d busy=%0b", n_done, busy1);
        #2;
        reset_n = 1'b1;
        step();
        run_op(1'b0);

        // Randomised operations with random idle gaps.
        for (int k = 0; k < 25; k++) begin
            x = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) step();
            run_op(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
